// File: rtl/mem_port_arbiter_pkg.sv
// Shared state encodings and port indices for the two-port memory arbiter.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN0 = 2'd1,
    ST_OWN1 = 2'd2
  } state_t;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_DMA = 1'b1;

  function automatic state_t own_state(input logic port);
    return (port == PORT_DMA) ? ST_OWN1 : ST_OWN0;
  endfunction

endpackage

// File: rtl/arb_rr2.sv
// Two-way picker: round-robin against the last winner, or fixed priority to port 0.
module arb_rr2
  import mem_port_arbiter_pkg::*;
#(
  parameter int RR = 1
) (
  input  logic [1:0] req,
  input  logic       last,
  output logic       winner,
  output logic       any
);

  always_comb begin
    any    = |req;
    winner = PORT_CPU;
    if (req == 2'b11) begin
      winner = (RR != 0) ? ~last : PORT_CPU;
    end else if (req[1]) begin
      winner = PORT_DMA;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one synchronous single-port memory between the CPU port and the DMA port,
// one access per cycle, with bounded locked bursts.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W   = 16,
  parameter int DATA_W   = 8,
  parameter int MAX_LOCK = 16,
  parameter int RR       = 1
) (
  input  logic              CLK100MHZ,
  input  logic              rst,
  input  logic              req0,
  input  logic              req1,
  input  logic              lock0,
  input  logic              lock1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int CNT_W = (MAX_LOCK > 1) ? $clog2(MAX_LOCK + 1) : 1;
  localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(MAX_LOCK - 1);

  state_t           state;
  logic             last;
  logic [CNT_W-1:0] lock_cnt;
  logic             arb_last;
  logic             winner;
  logic             any;
  logic             hold;

  assign gnt0 = (state == ST_OWN0) & req0;
  assign gnt1 = (state == ST_OWN1) & req1;

  // The arbiter sees the winner of this cycle as "last", so the
  // re-arbitration at the same edge already rotates away from it.
  assign arb_last = gnt0 ? PORT_CPU : (gnt1 ? PORT_DMA : last);
  assign hold     = ((gnt0 & lock0) | (gnt1 & lock1)) & (lock_cnt < LOCK_LAST);

  arb_rr2 #(.RR(RR)) u_arb (
    .req    ({req1, req0}),
    .last   (arb_last),
    .winner (winner),
    .any    (any)
  );

  always_ff @(posedge CLK100MHZ or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      last     <= PORT_DMA;
      lock_cnt <= '0;
      rvalid0  <= 1'b0;
      rvalid1  <= 1'b0;
    end else begin
      rvalid0 <= gnt0 & ~we0;
      rvalid1 <= gnt1 & ~we1;
      if (hold) begin
        lock_cnt <= lock_cnt + 1'b1;
      end else begin
        lock_cnt <= '0;
        last     <= arb_last;
        state    <= any ? own_state(winner) : ST_IDLE;
      end
    end
  end

  always_comb begin
    mem_en    = gnt0 | gnt1;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (gnt0) begin
      mem_we    = we0;
      mem_addr  = addr0;
      mem_wdata = wdata0;
    end else if (gnt1) begin
      mem_we    = we1;
      mem_addr  = addr1;
      mem_wdata = wdata1;
    end
  end

  assign rdata = (rvalid0 | rvalid1) ? mem_rdata : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Checks a round-robin and a fixed-priority arbiter against an ownership/burst model.
module tb_mem_port_arbiter;

  localparam int MAXL = 4;

  logic clk = 1'b0;
  logic rst;

  logic        req   [2][2];
  logic        lock  [2][2];
  logic        we    [2][2];
  logic [15:0] addr  [2][2];
  logic [7:0]  wdata [2][2];
  logic        gnt   [2][2];
  logic        rvalid[2][2];
  logic [7:0]  rdata [2];
  logic        mem_en[2];
  logic        mem_we[2];
  logic [15:0] mem_addr[2];
  logic [7:0]  mem_wdata[2];
  logic [7:0]  mem_rdata[2];

  bit [7:0] env_mem [2][65536];
  bit [7:0] ref_mem [2][65536];

  int       mown  [2];
  int       mrun  [2];
  bit       mlast [2];
  bit       mpend [2][2];
  bit [7:0] mpdata[2];
  bit       gotg  [2][2];
  int       gseq  [2][32];
  int       gn    [2];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(16), .DATA_W(8), .MAX_LOCK(MAXL), .RR(1)) dut_rr (
    .CLK100MHZ(clk), .rst(rst),
    .req0(req[0][0]), .req1(req[0][1]), .lock0(lock[0][0]), .lock1(lock[0][1]),
    .we0(we[0][0]), .we1(we[0][1]), .addr0(addr[0][0]), .addr1(addr[0][1]),
    .wdata0(wdata[0][0]), .wdata1(wdata[0][1]),
    .gnt0(gnt[0][0]), .gnt1(gnt[0][1]), .rvalid0(rvalid[0][0]), .rvalid1(rvalid[0][1]),
    .rdata(rdata[0]), .mem_en(mem_en[0]), .mem_we(mem_we[0]), .mem_addr(mem_addr[0]),
    .mem_wdata(mem_wdata[0]), .mem_rdata(mem_rdata[0])
  );

  mem_port_arbiter #(.ADDR_W(16), .DATA_W(8), .MAX_LOCK(MAXL), .RR(0)) dut_fp (
    .CLK100MHZ(clk), .rst(rst),
    .req0(req[1][0]), .req1(req[1][1]), .lock0(lock[1][0]), .lock1(lock[1][1]),
    .we0(we[1][0]), .we1(we[1][1]), .addr0(addr[1][0]), .addr1(addr[1][1]),
    .wdata0(wdata[1][0]), .wdata1(wdata[1][1]),
    .gnt0(gnt[1][0]), .gnt1(gnt[1][1]), .rvalid0(rvalid[1][0]), .rvalid1(rvalid[1][1]),
    .rdata(rdata[1]), .mem_en(mem_en[1]), .mem_we(mem_we[1]), .mem_addr(mem_addr[1]),
    .mem_wdata(mem_wdata[1]), .mem_rdata(mem_rdata[1])
  );

  // Synchronous memory behind each arbiter.
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (mem_en[k]) begin
        if (mem_we[k]) env_mem[k][mem_addr[k]] = mem_wdata[k];
        else mem_rdata[k] <= env_mem[k][mem_addr[k]];
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic string nmk(input int k, input string s);
    return $sformatf("i%0d_%s", k, s);
  endfunction

  task automatic model_cycle(input int k);
    bit       eg [2];
    logic     exp_we;
    logic [15:0] exp_addr;
    logic [7:0]  exp_wdata;
    bit       rr;
    rr = (k == 0);
    if (rst) begin
      mown[k] = -1; mrun[k] = 0; mlast[k] = 1'b1;
      mpend[k][0] = 1'b0; mpend[k][1] = 1'b0; mpdata[k] = 8'h00;
      gotg[k][0] = 1'b0; gotg[k][1] = 1'b0;
      chk(nmk(k, "rst_gnt0"), gnt[k][0], 0);
      chk(nmk(k, "rst_gnt1"), gnt[k][1], 0);
      chk(nmk(k, "rst_rvalid0"), rvalid[k][0], 0);
      chk(nmk(k, "rst_rvalid1"), rvalid[k][1], 0);
      chk(nmk(k, "rst_rdata"), rdata[k], 0);
      chk(nmk(k, "rst_mem_en"), mem_en[k], 0);
      chk(nmk(k, "rst_mem_addr"), mem_addr[k], 0);
      return;
    end
    exp_we = 1'b0; exp_addr = '0; exp_wdata = '0;
    for (int p = 0; p < 2; p++) begin
      eg[p] = (mown[k] == p) && req[k][p];
      if (eg[p]) begin
        exp_we = we[k][p]; exp_addr = addr[k][p]; exp_wdata = wdata[k][p];
      end
    end
    chk(nmk(k, "gnt0"), gnt[k][0], eg[0]);
    chk(nmk(k, "gnt1"), gnt[k][1], eg[1]);
    chk(nmk(k, "mem_en"), mem_en[k], eg[0] | eg[1]);
    chk(nmk(k, "mem_we"), mem_we[k], exp_we);
    chk(nmk(k, "mem_addr"), mem_addr[k], exp_addr);
    chk(nmk(k, "mem_wdata"), mem_wdata[k], exp_wdata);
    chk(nmk(k, "rvalid0"), rvalid[k][0], mpend[k][0]);
    chk(nmk(k, "rvalid1"), rvalid[k][1], mpend[k][1]);
    chk(nmk(k, "rdata"), rdata[k], (mpend[k][0] | mpend[k][1]) ? mpdata[k] : 8'h00);

    if (gnt[k][0] === 1'b1 || gnt[k][1] === 1'b1) begin
      if (gn[k] < 32) gseq[k][gn[k]] = (gnt[k][1] === 1'b1) ? 1 : 0;
      gn[k]++;
    end
    gotg[k][0] = (gnt[k][0] === 1'b1);
    gotg[k][1] = (gnt[k][1] === 1'b1);

    for (int p = 0; p < 2; p++) begin
      mpend[k][p] = 1'b0;
      if (eg[p]) begin
        if (we[k][p]) ref_mem[k][addr[k][p]] = wdata[k][p];
        else begin
          mpend[k][p] = 1'b1;
          mpdata[k] = ref_mem[k][addr[k][p]];
        end
      end
    end

    if (((eg[0] && lock[k][0]) || (eg[1] && lock[k][1])) && mrun[k] < MAXL - 1) begin
      mrun[k]++;
    end else begin
      if (eg[0]) mlast[k] = 1'b0;
      else if (eg[1]) mlast[k] = 1'b1;
      mrun[k] = 0;
      if (req[k][0] && req[k][1]) mown[k] = rr ? (mlast[k] ? 0 : 1) : 0;
      else if (req[k][0]) mown[k] = 0;
      else if (req[k][1]) mown[k] = 1;
      else mown[k] = -1;
    end
  endtask

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) model_cycle(k);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_port(input int p, input bit r, input bit l, input bit w,
                          input logic [15:0] a, input logic [7:0] d);
    for (int k = 0; k < 2; k++) begin
      req[k][p] = r; lock[k][p] = l; we[k][p] = w; addr[k][p] = a; wdata[k][p] = d;
    end
  endtask

  task automatic clr();
    set_port(0, 0, 0, 0, 16'h0000, 8'h00);
    set_port(1, 0, 0, 0, 16'h0000, 8'h00);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clr();
    repeat (2) tick();
    rst = 1'b0;
  endtask

  task automatic clr_log();
    gn[0] = 0;
    gn[1] = 0;
  endtask

  task automatic chk_seq(input string nm, input int k, input int n, input logic [7:0] pat);
    chk({nm, "_count"}, 32'(gn[k] >= n), 1);
    for (int i = 0; i < n; i++) chk($sformatf("%s_%0d", nm, i), gseq[k][i], 32'(pat[i]));
  endtask

  initial begin
    rst = 1'b1;
    clr();
    mem_rdata[0] = 8'h00;
    mem_rdata[1] = 8'h00;
    clr_log();

    @(negedge clk);
    chk("reset_gnt0", gnt[0][0], 0);
    chk("reset_mem_en", mem_en[0], 0);
    chk("reset_rdata", rdata[0], 0);
    tick(); tick();
    rst = 1'b0;

    // Single port 0: write then read back.
    set_port(0, 1, 0, 1, 16'h1234, 8'h5A);
    @(negedge clk); chk("t1_wr_idle", gnt[0][0], 0);
    @(negedge clk);
    chk("t1_wr_gnt", gnt[0][0], 1);
    chk("t1_wr_we", mem_we[0], 1);
    chk("t1_wr_addr", mem_addr[0], 16'h1234);
    chk("t1_wr_data", mem_wdata[0], 8'h5A);
    tick(); set_port(0, 1, 0, 0, 16'h1234, 8'h00);
    @(negedge clk);
    chk("t1_rd_gnt", gnt[0][0], 1);
    chk("t1_rd_we", mem_we[0], 0);
    tick(); set_port(0, 0, 0, 0, 16'h0000, 8'h00);
    @(negedge clk);
    chk("t1_rvalid0", rvalid[0][0], 1);
    chk("t1_rvalid1", rvalid[0][1], 0);
    chk("t1_rdata", rdata[0], 8'h5A);
    tick();

    // Continuous contention, no lock; then port 0 drops.
    do_reset();
    set_port(0, 1, 0, 0, 16'h0010, 8'h00);
    set_port(1, 1, 0, 0, 16'h0020, 8'h00);
    clr_log();
    repeat (6) tick();
    chk_seq("t2_rr", 0, 4, 8'b0000_1010);
    chk_seq("t2_fp", 1, 4, 8'b0000_0000);
    set_port(0, 0, 0, 0, 16'h0000, 8'h00);
    clr_log();
    repeat (3) tick();
    chk_seq("t5_rr_drop", 0, 1, 8'b0000_0001);
    chk_seq("t5_fp_drop", 1, 1, 8'b0000_0001);

    // Port 0 locks for a 3-access burst while port 1 waits.
    do_reset();
    set_port(0, 1, 1, 1, 16'h0030, 8'h11);
    set_port(1, 1, 0, 0, 16'h0030, 8'h00);
    clr_log();
    repeat (3) tick();
    set_port(0, 1, 0, 1, 16'h0030, 8'h11);
    repeat (3) tick();
    chk_seq("t3_rr", 0, 4, 8'b0000_1000);
    chk_seq("t3_fp", 1, 4, 8'b0000_0000);

    // Lock held forever: forced release after MAXL grants.
    do_reset();
    set_port(0, 1, 1, 0, 16'h0040, 8'h00);
    set_port(1, 1, 0, 1, 16'h0050, 8'h77);
    clr_log();
    repeat (8) tick();
    chk_seq("t4_rr", 0, 6, 8'b0001_0000);
    chk_seq("t4_fp", 1, 6, 8'b0000_0000);

    // Reset right after a port 1 read grant drops the pending rvalid.
    do_reset();
    set_port(1, 1, 0, 0, 16'h1234, 8'h00);
    tick();
    @(negedge clk); chk("t6_gnt1", gnt[0][1], 1);
    tick();
    rst = 1'b1;
    clr();
    @(negedge clk);
    chk("t6_rvalid1", rvalid[0][1], 0);
    chk("t6_rdata", rdata[0], 0);
    chk("t6_mem_en", mem_en[0], 0);
    chk("t6_gnt1_rst", gnt[0][1], 0);
    tick();
    rst = 1'b0;
    set_port(0, 1, 0, 0, 16'h0060, 8'h00);
    @(negedge clk); chk("t6_idle", gnt[0][0], 0);
    @(negedge clk); chk("t6_gnt0", gnt[0][0], 1);
    tick();
    clr();
    tick();

    // Randomized traffic, including occasional resets and address wrap region.
    repeat (3000) begin
      tick();
      rst = ($urandom_range(0, 249) == 0);
      for (int k = 0; k < 2; k++) begin
        for (int p = 0; p < 2; p++) begin
          if (!req[k][p] || gotg[k][p]) begin
            req[k][p]   = ($urandom_range(0, 3) != 0);
            lock[k][p]  = ($urandom_range(0, 3) != 0);
            we[k][p]    = $urandom_range(0, 1);
            addr[k][p]  = ($urandom_range(0, 1) == 1) ? 16'($urandom_range(0, 15))
                                                      : 16'hFFF8 + 16'($urandom_range(0, 7));
            wdata[k][p] = 8'($urandom_range(0, 255));
          end
        end
      end
    end
    rst = 1'b0;
    clr();
    repeat (4) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
